// File: rtl/traffic_sequencer.sv
// Purpose: RED->GREEN->YELLOW signal-head sequencer with pedestrian shortening, walk grant and emergency override.
// Latency: every output is registered; an input's effect is visible one clk after the edge that samples it.
// Backpressure: none; tick, ped_req and emergency are sampled every cycle and never stalled.
module traffic_sequencer #(
    parameter int RED_TIME    = 10,
    parameter int GREEN_TIME  = 8,
    parameter int YELLOW_TIME = 3,
    parameter int GREEN_MIN   = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             emergency,
    output logic [2:0]       current_state,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_walk
);

    typedef enum logic [2:0] {
        RED    = 3'b001,
        YELLOW = 3'b010,
        GREEN  = 3'b100
    } phase_t;

    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TIME - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] GMIN_LOAD   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    phase_t state;
    logic   ped_pending;
    logic   last_tick;
    logic   clamp;
    logic   to_red;

    assign last_tick = tick && (remaining == '0);
    // remaining >= GREEN_MIN, written against GREEN_MIN-1 so it never overflows CNT_W
    assign clamp     = (state == GREEN) && ped_pending && (remaining > GMIN_LOAD);
    assign to_red    = !emergency && (state == YELLOW) && last_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RED;
            remaining   <= RED_LOAD;
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            if (ped_req) begin
                ped_pending <= 1'b1;
            end else if (to_red) begin
                ped_pending <= 1'b0;
            end

            if (emergency) begin
                state     <= RED;
                remaining <= RED_LOAD;
                ped_walk  <= 1'b0;
            end else begin
                case (state)
                    RED: begin
                        if (last_tick) begin
                            state     <= GREEN;
                            remaining <= GREEN_LOAD;
                            ped_walk  <= 1'b0;
                        end else if (tick) begin
                            remaining <= remaining - ONE;
                        end
                    end
                    GREEN: begin
                        if (clamp) begin
                            remaining <= GMIN_LOAD;
                        end else if (last_tick) begin
                            state     <= YELLOW;
                            remaining <= YELLOW_LOAD;
                        end else if (tick) begin
                            remaining <= remaining - ONE;
                        end
                    end
                    YELLOW: begin
                        if (last_tick) begin
                            state     <= RED;
                            remaining <= RED_LOAD;
                            ped_walk  <= ped_pending;
                        end else if (tick) begin
                            remaining <= remaining - ONE;
                        end
                    end
                    default: begin
                        state     <= RED;
                        remaining <= RED_LOAD;
                        ped_walk  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign current_state = state;

endmodule
